// File: rtl/mycpu_pkg.sv
// Shared types and sizes for the register-bank write path.
// Requester identities double as round-robin slot indices.
// NREQ follows RB_WR_ARB_DBG_EN so every user sees the same arbiter width.
package mycpu_pkg;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_DBG = 2'd2
  } req_e;

  localparam int NREG   = 16;
  localparam int RSEL_W = 4;
  localparam int DATA_W = 16;

`ifdef RB_WR_ARB_DBG_EN
  localparam int NREQ = 3;
`else
  localparam int NREQ = 2;
`endif

  // Width of a pointer that indexes n requesters (at least 1 bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant over req_in starting at ptr_in, plus the slot after the winner.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; ungranted requesters simply see no grant this cycle.
module rr_arb #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_in,
  input  logic [PW-1:0] ptr_in,
  output logic [N-1:0]  gnt_out,
  output logic [PW-1:0] nxt_ptr_out
);

  logic          found;
  logic [PW-1:0] idx;
  int            j;

  // Scan from the priority pointer, wrapping once; first requester wins.
  always_comb begin
    gnt_out     = '0;
    nxt_ptr_out = ptr_in;
    found       = 1'b0;
    idx         = '0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_in) + i;
      if (j >= N) j = j - N;
      idx = PW'(j);
      if (!found && req_in[idx]) begin
        found        = 1'b1;
        gnt_out[idx] = 1'b1;
        nxt_ptr_out  = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
      end
    end
  end

endmodule

// File: rtl/rb_wr_arb.sv
// Register-bank write arbiter with pending-write scoreboard; RB_WR_ARB_DBG_EN adds the dbg requester.
// Latency: grant is combinational; the bank write (rw/wsel/d) appears 1 cycle after the transfer.
// Backpressure: p_ready_out is low for losers, who must hold request stable until granted.
module rb_wr_arb
  import mycpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_in,
  input  logic [RSEL_W-1:0] alu_wsel_in,
  input  logic [DATA_W-1:0] alu_d_in,
  output logic              alu_ready_out,
  input  logic              mem_valid_in,
  input  logic [RSEL_W-1:0] mem_wsel_in,
  input  logic [DATA_W-1:0] mem_d_in,
  output logic              mem_ready_out,
`ifdef RB_WR_ARB_DBG_EN
  input  logic              dbg_valid_in,
  input  logic [RSEL_W-1:0] dbg_wsel_in,
  input  logic [DATA_W-1:0] dbg_d_in,
  output logic              dbg_ready_out,
`endif
  input  logic              claim_in,
  input  logic [RSEL_W-1:0] claim_sel_in,
  output logic              rw_out,
  output logic [RSEL_W-1:0] wsel_out,
  output logic [DATA_W-1:0] d_out,
  output logic [NREG-1:0]   pend_out,
  output logic              waw_err_out
);

  localparam int PW = ptr_w(NREQ);

  logic [NREQ-1:0]   req_vld;
  logic [RSEL_W-1:0] req_wsel [NREQ];
  logic [DATA_W-1:0] req_dat  [NREQ];
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     nxt_ptr;
  logic              xfer;
  logic [RSEL_W-1:0] sel_wsel;
  logic [DATA_W-1:0] sel_dat;

  logic [PW-1:0]     ptr_q,   ptr_d;
  logic              rw_q,    rw_d;
  logic [RSEL_W-1:0] wsel_q,  wsel_d;
  logic [DATA_W-1:0] d_q,     d_d;
  logic [NREG-1:0]   pend_q,  pend_d;
  logic              waw_q,   waw_d;

  // Gather requester ports into arrays indexed by requester id.
  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_wsel[i] = '0;
      req_dat[i]  = '0;
    end
    req_vld[int'(REQ_ALU)]  = alu_valid_in;
    req_wsel[int'(REQ_ALU)] = alu_wsel_in;
    req_dat[int'(REQ_ALU)]  = alu_d_in;
    req_vld[int'(REQ_MEM)]  = mem_valid_in;
    req_wsel[int'(REQ_MEM)] = mem_wsel_in;
    req_dat[int'(REQ_MEM)]  = mem_d_in;
`ifdef RB_WR_ARB_DBG_EN
    req_vld[int'(REQ_DBG)]  = dbg_valid_in;
    req_wsel[int'(REQ_DBG)] = dbg_wsel_in;
    req_dat[int'(REQ_DBG)]  = dbg_d_in;
`endif
  end

  rr_arb #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_arb (
    .req_in      (req_vld),
    .ptr_in      (ptr_q),
    .gnt_out     (gnt),
    .nxt_ptr_out (nxt_ptr)
  );

  // Grants only count outside reset, so nothing transfers while rst_n is low.
  assign alu_ready_out = gnt[int'(REQ_ALU)] & rst_n;
  assign mem_ready_out = gnt[int'(REQ_MEM)] & rst_n;
`ifdef RB_WR_ARB_DBG_EN
  assign dbg_ready_out = gnt[int'(REQ_DBG)] & rst_n;
`endif
  assign xfer = (|gnt) & rst_n;

  // Mux the winner's payload, advance the pointer and update the scoreboard.
  always_comb begin
    sel_wsel = '0;
    sel_dat  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_wsel = sel_wsel | (req_wsel[i] & {RSEL_W{gnt[i]}});
      sel_dat  = sel_dat  | (req_dat[i]  & {DATA_W{gnt[i]}});
    end

    ptr_d  = ptr_q;
    rw_d   = xfer;
    wsel_d = wsel_q;
    d_d    = d_q;
    if (xfer) begin
      ptr_d  = nxt_ptr;
      wsel_d = sel_wsel;
      d_d    = sel_dat;
    end

    // Clear on the bank-capture edge first so a same-edge claim wins.
    pend_d = pend_q;
    if (rw_q) pend_d[wsel_q] = 1'b0;
    if (claim_in) pend_d[claim_sel_in] = 1'b1;

    waw_d = waw_q | (claim_in & pend_q[claim_sel_in] &
                     ~(rw_q && (wsel_q == claim_sel_in)));
  end

  // State registers; reset also drops any write still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= PW'(int'(REQ_ALU));
      rw_q   <= 1'b0;
      wsel_q <= '0;
      d_q    <= '0;
      pend_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      rw_q   <= rw_d;
      wsel_q <= wsel_d;
      d_q    <= d_d;
      pend_q <= pend_d;
      waw_q  <= waw_d;
    end
  end

  assign rw_out      = rw_q;
  assign wsel_out    = wsel_q;
  assign d_out       = d_q;
  assign pend_out    = pend_q;
  assign waw_err_out = waw_q;

endmodule

// File: tb/tb_rb_wr_arb.sv
// Directed bench for rb_wr_arb: arbitration order, write latency, scoreboard and reset.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
// Builds with or without RB_WR_ARB_DBG_EN.
module tb_rb_wr_arb;
  import mycpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              alu_valid_in, mem_valid_in;
  logic [RSEL_W-1:0] alu_wsel_in, mem_wsel_in;
  logic [DATA_W-1:0] alu_d_in, mem_d_in;
  logic              alu_ready_out, mem_ready_out;
`ifdef RB_WR_ARB_DBG_EN
  logic              dbg_valid_in;
  logic [RSEL_W-1:0] dbg_wsel_in;
  logic [DATA_W-1:0] dbg_d_in;
  logic              dbg_ready_out;
`endif
  logic              claim_in;
  logic [RSEL_W-1:0] claim_sel_in;
  logic              rw_out;
  logic [RSEL_W-1:0] wsel_out;
  logic [DATA_W-1:0] d_out;
  logic [NREG-1:0]   pend_out;
  logic              waw_err_out;

  int checks   = 0;
  int failures = 0;

  rb_wr_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid_in  (alu_valid_in),
    .alu_wsel_in   (alu_wsel_in),
    .alu_d_in      (alu_d_in),
    .alu_ready_out (alu_ready_out),
    .mem_valid_in  (mem_valid_in),
    .mem_wsel_in   (mem_wsel_in),
    .mem_d_in      (mem_d_in),
    .mem_ready_out (mem_ready_out),
`ifdef RB_WR_ARB_DBG_EN
    .dbg_valid_in  (dbg_valid_in),
    .dbg_wsel_in   (dbg_wsel_in),
    .dbg_d_in      (dbg_d_in),
    .dbg_ready_out (dbg_ready_out),
`endif
    .claim_in      (claim_in),
    .claim_sel_in  (claim_sel_in),
    .rw_out        (rw_out),
    .wsel_out      (wsel_out),
    .d_out         (d_out),
    .pend_out      (pend_out),
    .waw_err_out   (waw_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    alu_valid_in = 1'b1;
    alu_wsel_in  = '0;
    alu_d_in     = '0;
    mem_valid_in = 1'b0;
    mem_wsel_in  = '0;
    mem_d_in     = '0;
`ifdef RB_WR_ARB_DBG_EN
    dbg_valid_in = 1'b0;
    dbg_wsel_in  = '0;
    dbg_d_in     = '0;
`endif
    claim_in     = 1'b0;
    claim_sel_in = '0;

    // Reset state, with a request present that must not be granted
    tick(); tick();
    check("rst_rw",        32'(rw_out),        32'd0);
    check("rst_wsel",      32'(wsel_out),      32'd0);
    check("rst_d",         32'(d_out),         32'd0);
    check("rst_pend",      32'(pend_out),      32'd0);
    check("rst_err",       32'(waw_err_out),   32'd0);
    check("rst_alu_ready", 32'(alu_ready_out), 32'd0);
    check("rst_mem_ready", 32'(mem_ready_out), 32'd0);
    alu_valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single alu write, 1-cycle latency
    alu_valid_in = 1'b1; alu_wsel_in = 4'd3; alu_d_in = 16'hBEEF;
    #1;
    check("t1_alu_ready", 32'(alu_ready_out), 32'd1);
    check("t1_mem_ready", 32'(mem_ready_out), 32'd0);
    tick();
    alu_valid_in = 1'b0;
    #1;
    check("t1_rw",   32'(rw_out),   32'd1);
    check("t1_wsel", 32'(wsel_out), 32'd3);
    check("t1_d",    32'(d_out),    32'h0000BEEF);
    tick();
    check("t1_rw_off",   32'(rw_out),   32'd0);
    check("t1_wsel_hold", 32'(wsel_out), 32'd3);
    check("t1_d_hold",   32'(d_out),    32'h0000BEEF);
    tick(); tick();

    // All requesters valid; pointer sits at mem after the alu transfer
    alu_valid_in = 1'b1; alu_wsel_in = 4'd1; alu_d_in = 16'h1111;
    mem_valid_in = 1'b1; mem_wsel_in = 4'd2; mem_d_in = 16'h2222;
`ifdef RB_WR_ARB_DBG_EN
    dbg_valid_in = 1'b1; dbg_wsel_in = 4'd4; dbg_d_in = 16'h4444;
`endif
    #1;
    check("t2_g0_mem", 32'(mem_ready_out), 32'd1);
    check("t2_g0_alu", 32'(alu_ready_out), 32'd0);
    tick();
    mem_valid_in = 1'b0;
`ifdef RB_WR_ARB_DBG_EN
    #1;
    check("t2_g1_dbg", 32'(dbg_ready_out), 32'd1);
    check("t2_g1_alu", 32'(alu_ready_out), 32'd0);
    check("t2_w0_rw",  32'(rw_out),        32'd1);
    check("t2_w0_sel", 32'(wsel_out),      32'd2);
    check("t2_w0_d",   32'(d_out),         32'h2222);
    tick();
    dbg_valid_in = 1'b0;
    #1;
    check("t2_g2_alu", 32'(alu_ready_out), 32'd1);
    check("t2_w1_rw",  32'(rw_out),        32'd1);
    check("t2_w1_sel", 32'(wsel_out),      32'd4);
    check("t2_w1_d",   32'(d_out),         32'h4444);
`else
    #1;
    check("t2_g1_alu", 32'(alu_ready_out), 32'd1);
    check("t2_w0_rw",  32'(rw_out),        32'd1);
    check("t2_w0_sel", 32'(wsel_out),      32'd2);
    check("t2_w0_d",   32'(d_out),         32'h2222);
`endif
    tick();
    alu_valid_in = 1'b0;
    #1;
    check("t2_wl_rw",  32'(rw_out),   32'd1);
    check("t2_wl_sel", 32'(wsel_out), 32'd1);
    check("t2_wl_d",   32'(d_out),    32'h1111);
    tick();
    check("t2_rw_off", 32'(rw_out), 32'd0);

    // Claim 5, then mem writes 5; bit clears at the end of the rw cycle
    claim_in = 1'b1; claim_sel_in = 4'd5;
    tick();
    claim_in = 1'b0;
    check("t3_pend_set", 32'(pend_out), 32'h0020);
    mem_valid_in = 1'b1; mem_wsel_in = 4'd5; mem_d_in = 16'h5555;
    #1;
    check("t3_mem_ready", 32'(mem_ready_out), 32'd1);
    tick();
    mem_valid_in = 1'b0;
    #1;
    check("t3_rw",         32'(rw_out),   32'd1);
    check("t3_pend_hold",  32'(pend_out), 32'h0020);
    tick();
    check("t3_pend_clr",   32'(pend_out), 32'h0000);
    check("t3_err",        32'(waw_err_out), 32'd0);

    // Claim 7, write 7, re-claim 7 on the clearing edge: set wins, no error
    claim_in = 1'b1; claim_sel_in = 4'd7;
    tick();
    claim_in = 1'b0;
    check("t4_pend_set", 32'(pend_out), 32'h0080);
    alu_valid_in = 1'b1; alu_wsel_in = 4'd7; alu_d_in = 16'h7777;
    #1;
    check("t4_alu_ready", 32'(alu_ready_out), 32'd1);
    tick();
    alu_valid_in = 1'b0;
    claim_in = 1'b1; claim_sel_in = 4'd7;
    #1;
    check("t4_rw",   32'(rw_out),   32'd1);
    check("t4_wsel", 32'(wsel_out), 32'd7);
    tick();
    claim_in = 1'b0;
    #1;
    check("t4_pend_kept", 32'(pend_out),    32'h0080);
    check("t4_err",       32'(waw_err_out), 32'd0);

    // Double claim of 2 raises a sticky error; reset clears it
    claim_in = 1'b1; claim_sel_in = 4'd2;
    tick();
    check("t5_err_first", 32'(waw_err_out), 32'd0);
    tick();
    claim_in = 1'b0;
    check("t5_err_set", 32'(waw_err_out), 32'd1);
    check("t5_pend",    32'(pend_out),    32'h0084);
    tick(); tick(); tick();
    check("t5_err_sticky", 32'(waw_err_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_err_rst",  32'(waw_err_out), 32'd0);
    check("t5_pend_rst", 32'(pend_out),    32'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the cycle after a transfer drops the write and rewinds the pointer
    alu_valid_in = 1'b1; alu_wsel_in = 4'd9; alu_d_in = 16'h9999;
    #1;
    check("t6_alu_ready", 32'(alu_ready_out), 32'd1);
    tick();
    alu_valid_in = 1'b0;
    #1;
    check("t6_rw_pre", 32'(rw_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rw_rst",   32'(rw_out),   32'd0);
    check("t6_wsel_rst", 32'(wsel_out), 32'd0);
    check("t6_d_rst",    32'(d_out),    32'd0);
    tick();
    check("t6_rw_still", 32'(rw_out), 32'd0);
    rst_n = 1'b1;
    tick();
    alu_valid_in = 1'b1; alu_wsel_in = 4'd10; alu_d_in = 16'hAAAA;
    mem_valid_in = 1'b1; mem_wsel_in = 4'd11; mem_d_in = 16'hBBBB;
    #1;
    check("t6_ptr_alu", 32'(alu_ready_out), 32'd1);
    check("t6_ptr_mem", 32'(mem_ready_out), 32'd0);
    tick();
    alu_valid_in = 1'b0;
    #1;
    check("t6_mem_next", 32'(mem_ready_out), 32'd1);
    check("t6_w0_sel",   32'(wsel_out),      32'd10);
    check("t6_w0_d",     32'(d_out),         32'hAAAA);
    tick();
    mem_valid_in = 1'b0;
    #1;
    check("t6_w1_rw",   32'(rw_out),      32'd1);
    check("t6_w1_sel",  32'(wsel_out),    32'd11);
    check("t6_w1_d",    32'(d_out),       32'hBBBB);
    check("t6_pend",    32'(pend_out),    32'h0000);
    check("t6_err",     32'(waw_err_out), 32'd0);
    tick();
    check("t6_rw_off", 32'(rw_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rb_wr_arb.md
RB_WR_ARB -- requirements
Module: rb_wr_arb

Interface
REQ-001 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have, for p in {alu, mem, dbg}: p_valid_in  input  1  write request; p_wsel_in  input  4  destination register; p_d_in  input  16  write data; p_ready_out  output  1  grant.
REQ-004 SHALL have claim_in  input  1  issue stage reserves a destination register.
REQ-005 SHALL have claim_sel_in  input  4  register being reserved.
REQ-006 SHALL have rw_out  output  1  register-bank write enable.
REQ-007 SHALL have wsel_out  output  4  register-bank write select.
REQ-008 SHALL have d_out  output  16  register-bank write data.
REQ-009 SHALL have pend_out  output  16  per-register pending-write scoreboard.
REQ-010 SHALL have waw_err_out  output  1  sticky write-after-write claim error.

Function
REQ-011 SHALL grant at most one requester per cycle by round-robin over valid requesters, order alu -> mem -> dbg -> alu.
REQ-012 SHALL drive p_ready_out combinationally high only for the granted requester, and only when that requester's p_valid_in is high.
REQ-013 SHALL, after a transfer (p_valid_in & p_ready_out), make the requester following the granted one highest priority on the next cycle.
REQ-014 SHALL leave the priority pointer unchanged in cycles with no transfer.
REQ-015 SHALL keep requester p_valid_in, p_wsel_in and p_d_in stable until transfer; the block does not check this.
REQ-016 SHALL register each transfer so that rw_out=1, wsel_out=p_wsel_in and d_out=p_d_in in the cycle after the transfer (1-cycle latency).
REQ-017 SHALL drive rw_out=0 in any cycle not following a transfer; wsel_out and d_out hold their last values.
REQ-018 SHALL sustain one write per cycle under continuous requests (no bubbles).
REQ-019 SHALL set pend_out[claim_sel_in] at the edge where claim_in=1.
REQ-020 SHALL clear pend_out[wsel_out] at the edge where rw_out=1, the edge on which the bank captures the data.
REQ-021 SHALL keep the bit set when a claim and a clear target the same register on the same edge (set wins).
REQ-022 SHALL set waw_err_out when claim_in=1 targets a register whose pend bit is already 1 and not clearing that edge; the bit is held until reset.
REQ-023 SHALL ignore a write to a register whose pend bit is 0 for scoreboard purposes; no error is raised.

Reset
REQ-024 SHALL, while rst_n=0, force rw_out=0, wsel_out=0, d_out=0, pend_out=0, waw_err_out=0, and the priority pointer to alu.
REQ-025 SHALL discard any registered write in flight when reset asserts mid-operation; no write reaches the bank.
REQ-026 SHALL hold all p_ready_out=0 while rst_n=0.

Configuration
REQ-027 SHALL, with RB_WR_ARB_DBG_EN defined, include the dbg_* ports and a 3-way round-robin.
REQ-028 SHALL, without RB_WR_ARB_DBG_EN, omit the dbg_* ports and use a 2-way alu/mem round-robin; all other behaviour is unchanged.

Structure
REQ-029 SHALL take the requester enum (REQ_ALU, REQ_MEM, REQ_DBG), NREG=16, RSEL_W=4 and DATA_W=16 from mycpu_pkg.
REQ-030 SHALL implement the arbitration in one sub-module, rr_arb, parameterised by requester count, returning a one-hot grant and the next pointer.
REQ-031 SHALL keep the scoreboard and the output register stage in rb_wr_arb.

Verification
REQ-032 SHALL show, from reset, alu_valid=1 (wsel=3, d=0xBEEF) for one cycle -> alu_ready=1 that cycle; next cycle rw_out=1, wsel_out=3, d_out=0xBEEF; the following cycle rw_out=0.
REQ-033 SHALL show alu, mem and dbg all valid for 3 cycles -> grants alu, mem, dbg in order; rw_out=1 for 3 consecutive cycles with the matching data.
REQ-034 SHALL show claim_in with sel=5, then a mem write to 5 -> pend_out[5]=1 until the edge ending the rw_out=1 cycle, then 0.
REQ-035 SHALL show a claim of sel=7 on the same edge that rw_out=1 clears wsel_out=7 -> pend_out[7] remains 1 and waw_err_out remains 0.
REQ-036 SHALL show a claim of sel=2 twice without an intervening write -> waw_err_out=1 and sticky; rst_n pulse -> 0.
REQ-037 SHALL show rst_n asserted in the cycle after a transfer -> rw_out=0 and no write reaches the bank; after reset release the pointer is alu.
